// File: rtl/hex_keypad_entry.sv
// hex_keypad_entry: 4x4 hex keypad scanner with debounce and a 16-bit
// nibble-entry register that feeds the display value inputs.
// Optional feature: define KEYPAD_BACKSPACE_EN so the '*' key (code E)
// drops the newest nibble instead of shifting in E.
module hex_keypad_entry #(
  parameter int SCAN_DIV       = 100_000,  // clocks per column step, >= 4
  parameter int DEBOUNCE_SCANS = 4         // full scans to accept, 1..15
) (
  input  logic        clk_100MHz_i,
  input  logic        rst_n,
  input  logic [3:0]  row_i,
  input  logic        clr_i,
  output logic [3:0]  col_o,
  output logic        key_valid_o,
  output logic [3:0]  key_code_o,
  output logic        key_held_o,
  output logic [15:0] value_o
);

  localparam int             DW      = $clog2(SCAN_DIV);
  localparam logic [DW-1:0]  DIV_MAX = DW'(SCAN_DIV - 1);
  localparam logic [3:0]     DB      = 4'(DEBOUNCE_SCANS);
`ifdef KEYPAD_BACKSPACE_EN
  localparam bit             BS_EN   = 1'b1;
`else
  localparam bit             BS_EN   = 1'b0;
`endif

  // scan classification: saturating key count per full scan
  localparam logic [1:0] CLS_NONE   = 2'd0;
  localparam logic [1:0] CLS_SINGLE = 2'd1;
  localparam logic [1:0] CLS_MULTI  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE, ST_DEBOUNCE, ST_PRESSED, ST_RELEASE
  } state_e;

  // keypad legend: row-major, '*' = E, '#' = F
  function automatic logic [3:0] decode(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
      4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
      4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
      4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  default: code = 4'hD;
    endcase
    return code;
  endfunction

  logic [3:0]    row_s1_q, row_s2_q;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    col_idx_q, col_idx_d;
  logic          tick, scan_done;

  logic [1:0]    acc_cnt_q, acc_cnt_d;
  logic [1:0]    last_row_q, last_row_d;
  logic [1:0]    last_col_q, last_col_d;
  logic [1:0]    scan_cnt;      // saturated count including current column
  logic [1:0]    scan_row, scan_col;
  logic [3:0]    scan_code;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [3:0]    cand_q, cand_d;
  logic          accept, backspace;

  logic          key_valid_q, key_valid_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_held_q, key_held_d;
  logic [15:0]   value_q, value_d;

  // two-flop synchroniser for the asynchronous row lines (idle = all high)
  always_ff @(posedge clk_100MHz_i or negedge rst_n) begin
    if (!rst_n) begin
      row_s1_q <= 4'hF;
      row_s2_q <= 4'hF;
    end else begin
      row_s1_q <= row_i;
      row_s2_q <= row_s1_q;
    end
  end

  // column divider: rows are sampled on tick, then the strobe advances
  always_comb begin
    tick      = (div_q == DIV_MAX);
    scan_done = tick && (col_idx_q == 2'd3);
    div_d     = tick ? '0 : div_q + 1'b1;
    col_idx_d = tick ? col_idx_q + 2'd1 : col_idx_q;
  end

  assign col_o = ~(4'b0001 << col_idx_q);

  // per-scan accumulation; the column sampled on scan_done is folded in
  // combinationally so classification sees the whole scan
  always_comb begin
    logic [2:0] hits;
    logic [2:0] tot;
    logic [1:0] hit_row;
    hits    = '0;
    hit_row = '0;
    for (int r = 0; r < 4; r++) begin
      if (!row_s2_q[r]) begin
        hits    = hits + 3'd1;
        hit_row = 2'(r);
      end
    end
    tot      = {1'b0, acc_cnt_q} + hits;
    scan_cnt = (tot >= 3'd2) ? CLS_MULTI : tot[1:0];
    scan_row = (hits != '0) ? hit_row   : last_row_q;
    scan_col = (hits != '0) ? col_idx_q : last_col_q;
    scan_code = decode(scan_row, scan_col);

    acc_cnt_d  = acc_cnt_q;
    last_row_d = last_row_q;
    last_col_d = last_col_q;
    if (scan_done) begin
      acc_cnt_d  = '0;
      last_row_d = '0;
      last_col_d = '0;
    end else if (tick) begin
      acc_cnt_d  = scan_cnt;
      last_row_d = scan_row;
      last_col_d = scan_col;
    end
  end

  // debounce FSM: advances only at the end of each full scan
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    accept  = 1'b0;
    if (scan_done) begin
      case (state_q)
        ST_IDLE: begin
          if (scan_cnt == CLS_SINGLE) begin
            cand_d = scan_code;
            cnt_d  = 4'd1;
            if (DB == 4'd1) begin
              state_d = ST_PRESSED;
              accept  = 1'b1;
            end else begin
              state_d = ST_DEBOUNCE;
            end
          end
        end
        ST_DEBOUNCE: begin
          if (scan_cnt == CLS_SINGLE && scan_code == cand_q) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q + 4'd1 == DB) begin
              state_d = ST_PRESSED;
              accept  = 1'b1;
            end
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
        ST_PRESSED: begin
          // held keys never repeat; only a clean release moves on
          if (scan_cnt == CLS_NONE) begin
            if (DB == 4'd1) begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end else begin
              state_d = ST_RELEASE;
              cnt_d   = 4'd1;
            end
          end
        end
        default: begin // ST_RELEASE
          if (scan_cnt == CLS_NONE) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q + 4'd1 == DB) begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end
          end else begin
            state_d = ST_PRESSED;
            cnt_d   = '0;
          end
        end
      endcase
    end
  end

  // accept action and clear; clear wins except for the freshly accepted nibble
  always_comb begin
    backspace   = BS_EN && accept && (cand_d == 4'hE);
    key_valid_d = accept;
    key_code_d  = accept ? cand_d : key_code_q;
    key_held_d  = (state_d == ST_PRESSED) || (state_d == ST_RELEASE);
    value_d     = value_q;
    if (accept)
      value_d = backspace ? {4'h0, value_q[15:4]} : {value_q[11:0], cand_d};
    if (clr_i)
      value_d = (accept && !backspace) ? {12'h000, cand_d} : 16'h0000;
  end

  // state and output registers
  always_ff @(posedge clk_100MHz_i or negedge rst_n) begin
    if (!rst_n) begin
      div_q       <= '0;
      col_idx_q   <= '0;
      acc_cnt_q   <= '0;
      last_row_q  <= '0;
      last_col_q  <= '0;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cand_q      <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      key_held_q  <= 1'b0;
      value_q     <= '0;
    end else begin
      div_q       <= div_d;
      col_idx_q   <= col_idx_d;
      acc_cnt_q   <= acc_cnt_d;
      last_row_q  <= last_row_d;
      last_col_q  <= last_col_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      key_held_q  <= key_held_d;
      value_q     <= value_d;
    end
  end

  assign key_valid_o = key_valid_q;
  assign key_code_o  = key_code_q;
  assign key_held_o  = key_held_q;
  assign value_o     = value_q;

endmodule
